cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/sys_defs.sv | 20 ++
 rtl/cdb_arbiter_fifo.sv | 56 +++++
 rtl/cdb_arbiter.sv | 109 ++++++++++
 tb/tb_cdb_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/sys_defs.sv
// Shared machine-wide widths and the CDB broadcast packet.
// No logic: types and constants only.
// Imported by every back-end block that touches the CDB.
package sys_defs;
  localparam int XLEN      = 32;
  localparam int ROB_IDX_W = 5;
  localparam int N_FU      = 4;
  localparam int CDB_W     = 2;

  typedef struct packed {
    logic                 valid;
    logic [ROB_IDX_W-1:0] tag;
    logic [XLEN-1:0]      value;
  } CDB_PACKET;

  typedef struct packed {
    logic [ROB_IDX_W-1:0] tag;
    logic [XLEN-1:0]      value;
  } rb_entry_t;
endpackage

// File: rtl/cdb_arbiter_fifo.sv
// Per-FU result buffer: DEPTH-entry FIFO of {tag, value}.
// Head is combinational from storage; push/pop/flush take effect at the edge.
// Push into a full buffer is dropped unless a pop frees the slot in the same cycle.
module fu_result_fifo
  import sys_defs::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  rb_entry_t              push_dat,
  output rb_entry_t              head,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  rb_entry_t      mem [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic           full;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && (count != '0) && !flush;
  assign do_push = push && !flush && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end
endmodule

// File: rtl/cdb_arbiter.sv
// Buffers FU results and broadcasts up to CDB_W per cycle, round-robin across FUs.
// Latency: result sampled at edge E appears on cdb_* after edge E+1.
// fu_ready drops when a buffer cannot absorb both an in-flight result and a new issue.
module cdb_arbiter
  import sys_defs::XLEN, sys_defs::ROB_IDX_W, sys_defs::CDB_PACKET, sys_defs::rb_entry_t;
#(
  parameter int N_FU     = sys_defs::N_FU,
  parameter int RB_DEPTH = 4,
  parameter int CDB_W    = sys_defs::CDB_W
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                refresh,
  input  logic [N_FU-1:0]                     fu_valid,
  input  logic [N_FU-1:0][XLEN-1:0]           fu_result,
  input  logic [N_FU-1:0][ROB_IDX_W-1:0]      fu_tag,
  output logic [N_FU-1:0]                     fu_ready,
  output logic [CDB_W-1:0]                    cdb_valid,
  output logic [CDB_W-1:0][XLEN-1:0]          cdb_value,
  output logic [CDB_W-1:0][ROB_IDX_W-1:0]     cdb_tag,
  output logic                                overflow_err
);
  localparam int CW  = $clog2(RB_DEPTH) + 1;
  localparam int RRW = (N_FU > 1) ? $clog2(N_FU) : 1;
  localparam logic [CW-1:0] READY_MAX = CW'(RB_DEPTH - 2);
  localparam logic [CW-1:0] FULL_CNT  = CW'(RB_DEPTH);

  rb_entry_t                   head  [N_FU];
  logic [CW-1:0]               count [N_FU];
  logic [N_FU-1:0]             granted;
  logic [N_FU-1:0]             drop;
  logic [CDB_W-1:0]            lane_vld;
  logic [CDB_W-1:0][RRW-1:0]   lane_src;
  logic [RRW-1:0]              rr;
  logic [RRW-1:0]              rr_nxt;
  CDB_PACKET [CDB_W-1:0]       cdb_pkt;
  CDB_PACKET [CDB_W-1:0]       cdb_nxt;
  int                          idx;
  int                          n_grant;

  for (genvar i = 0; i < N_FU; i++) begin : g_fu
    fu_result_fifo #(.DEPTH(RB_DEPTH)) u_fifo (
      .clock    (clock),
      .reset    (reset),
      .push     (fu_valid[i]),
      .pop      (granted[i]),
      .flush    (refresh),
      .push_dat ({fu_tag[i], fu_result[i]}),
      .head     (head[i]),
      .count    (count[i])
    );
    assign fu_ready[i] = (count[i] <= READY_MAX);
    // Full after this cycle's pop means the arriving result has nowhere to go.
    assign drop[i]     = fu_valid[i] && (count[i] == FULL_CNT) && !granted[i];
  end

  // Scan from rr with wrap; the first CDB_W non-empty buffers win lanes in order.
  always_comb begin
    granted  = '0;
    lane_vld = '0;
    lane_src = '0;
    rr_nxt   = rr;
    n_grant  = 0;
    idx      = 0;
    for (int k = 0; k < N_FU; k++) begin
      idx = int'(rr) + k;
      if (idx >= N_FU) idx = idx - N_FU;
      if ((n_grant < CDB_W) && (count[idx] != '0)) begin
        granted[idx]      = 1'b1;
        lane_vld[n_grant] = 1'b1;
        lane_src[n_grant] = RRW'(idx);
        n_grant           = n_grant + 1;
        rr_nxt            = RRW'((idx + 1) % N_FU);
      end
    end
  end

  always_comb begin
    cdb_nxt = '0;
    for (int l = 0; l < CDB_W; l++) begin
      if (lane_vld[l]) begin
        cdb_nxt[l].valid = 1'b1;
        cdb_nxt[l].tag   = head[lane_src[l]].tag;
        cdb_nxt[l].value = head[lane_src[l]].value;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cdb_pkt      <= '0;
      rr           <= '0;
      overflow_err <= 1'b0;
    end else if (refresh) begin
      cdb_pkt      <= '0;
      rr           <= '0;
    end else begin
      cdb_pkt      <= cdb_nxt;
      rr           <= rr_nxt;
      overflow_err <= overflow_err | (|drop);
    end
  end

  for (genvar l = 0; l < CDB_W; l++) begin : g_lane
    assign cdb_valid[l] = cdb_pkt[l].valid;
    assign cdb_tag[l]   = cdb_pkt[l].tag;
    assign cdb_value[l] = cdb_pkt[l].value;
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed table, corner sequences, randomized traffic vs queue model.
module tb_cdb_arbiter;
  import sys_defs::XLEN, sys_defs::ROB_IDX_W;

  localparam int NF  = 4;
  localparam int DEP = 4;
  localparam int NL  = 2;

  logic                               clock = 1'b0;
  logic                               reset = 1'b0;
  logic                               refresh = 1'b0;
  logic [NF-1:0]                      fu_valid = '0;
  logic [NF-1:0][XLEN-1:0]            fu_result = '0;
  logic [NF-1:0][ROB_IDX_W-1:0]       fu_tag = '0;
  logic [NF-1:0]                      fu_ready;
  logic [NL-1:0]                      cdb_valid;
  logic [NL-1:0][XLEN-1:0]            cdb_value;
  logic [NL-1:0][ROB_IDX_W-1:0]       cdb_tag;
  logic                               overflow_err;

  cdb_arbiter #(.N_FU(NF), .RB_DEPTH(DEP), .CDB_W(NL)) dut (
    .clock        (clock),
    .reset        (reset),
    .refresh      (refresh),
    .fu_valid     (fu_valid),
    .fu_result    (fu_result),
    .fu_tag       (fu_tag),
    .fu_ready     (fu_ready),
    .cdb_valid    (cdb_valid),
    .cdb_value    (cdb_value),
    .cdb_tag      (cdb_tag),
    .overflow_err (overflow_err)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [ROB_IDX_W-1:0] tag;
    logic [XLEN-1:0]      val;
  } ent_t;

  ent_t                       q [NF][$];
  int                         m_rr = 0;
  logic                       m_ovf = 1'b0;
  logic [NL-1:0]              m_vld = '0;
  logic [NL-1:0][ROB_IDX_W-1:0] m_tag = '0;
  logic [NL-1:0][XLEN-1:0]    m_val = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NF-1:0] m_ready();
    logic [NF-1:0] r;
    for (int i = 0; i < NF; i++) r[i] = (q[i].size() <= DEP - 2);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NF; i++) q[i].delete();
    m_rr = 0; m_ovf = 1'b0; m_vld = '0; m_tag = '0; m_val = '0;
  endtask

  // One clock edge of the reference: broadcast round-robin heads, then accept arrivals.
  task automatic model_edge(input logic [NF-1:0] v, input logic rf);
    int   n, last, id;
    ent_t e;
    m_vld = '0; m_tag = '0; m_val = '0;
    if (rf) begin
      for (int i = 0; i < NF; i++) q[i].delete();
      m_rr = 0;
      return;
    end
    n = 0; last = -1;
    for (int k = 0; k < NF; k++) begin
      id = (m_rr + k) % NF;
      if (n < NL && q[id].size() > 0) begin
        e = q[id].pop_front();
        m_vld[n] = 1'b1; m_tag[n] = e.tag; m_val[n] = e.val;
        n++; last = id;
      end
    end
    if (last >= 0) m_rr = (last + 1) % NF;
    for (int i = 0; i < NF; i++) begin
      if (v[i]) begin
        if (q[i].size() >= DEP) m_ovf = 1'b1;
        else begin
          e.tag = fu_tag[i]; e.val = fu_result[i];
          q[i].push_back(e);
        end
      end
    end
  endtask

  // Called at a negedge with fu_tag/fu_result already set; returns at the next negedge.
  task automatic step(input logic [NF-1:0] v, input logic rf);
    fu_valid = v; refresh = rf;
    chk("fu_ready_pre", fu_ready, m_ready());
    model_edge(v, rf);
    @(posedge clock); #1;
    chk("cdb_valid", cdb_valid, m_vld);
    for (int l = 0; l < NL; l++) begin
      chk("cdb_tag", cdb_tag[l], m_tag[l]);
      chk("cdb_value", cdb_value[l], m_val[l]);
    end
    chk("overflow_err", overflow_err, m_ovf);
    @(negedge clock);
    fu_valid = '0; refresh = 1'b0;
  endtask

  typedef struct {
    logic [NF-1:0]                vld;
    logic                         rf;
    logic [NF-1:0][ROB_IDX_W-1:0] tags;
    logic [NL-1:0]                ev;
    logic [ROB_IDX_W-1:0]         et0;
    logic [ROB_IDX_W-1:0]         et1;
  } vec_t;

  vec_t tbl [10];
  int   drops;
  int   bcasts;

  initial begin
    // Directed table; value for each pushed result is tag + 2.
    tbl[0] = '{4'b0100, 1'b0, {5'd0, 5'd5, 5'd0, 5'd0},     2'b00, 5'd0, 5'd0};
    tbl[1] = '{4'b0000, 1'b0, {5'd0, 5'd0, 5'd0, 5'd0},     2'b01, 5'd5, 5'd0};
    tbl[2] = '{4'b0111, 1'b0, {5'd0, 5'd12, 5'd11, 5'd10},  2'b00, 5'd0, 5'd0};
    tbl[3] = '{4'b1111, 1'b1, {5'd23, 5'd22, 5'd21, 5'd20}, 2'b00, 5'd0, 5'd0};
    tbl[4] = '{4'b1111, 1'b0, {5'd4, 5'd3, 5'd2, 5'd1},     2'b00, 5'd0, 5'd0};
    tbl[5] = '{4'b0000, 1'b0, {5'd0, 5'd0, 5'd0, 5'd0},     2'b11, 5'd1, 5'd2};
    tbl[6] = '{4'b0000, 1'b0, {5'd0, 5'd0, 5'd0, 5'd0},     2'b11, 5'd3, 5'd4};
    tbl[7] = '{4'b1010, 1'b0, {5'd9, 5'd0, 5'd8, 5'd0},     2'b00, 5'd0, 5'd0};
    tbl[8] = '{4'b0001, 1'b0, {5'd0, 5'd0, 5'd0, 5'd6},     2'b11, 5'd8, 5'd9};
    tbl[9] = '{4'b0000, 1'b0, {5'd0, 5'd0, 5'd0, 5'd0},     2'b01, 5'd6, 5'd0};

    // Reset state, held over a couple of edges.
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_cdb_valid", cdb_valid, '0);
    chk("rst_cdb_tag", cdb_tag, '0);
    chk("rst_cdb_value", cdb_value, '0);
    chk("rst_fu_ready", fu_ready, 4'hF);
    chk("rst_overflow", overflow_err, 1'b0);
    @(negedge clock);
    reset = 1'b1;

    for (int r = 0; r < 10; r++) begin
      fu_tag = tbl[r].tags;
      for (int i = 0; i < NF; i++) fu_result[i] = XLEN'(tbl[r].tags[i]) + 32'd2;
      step(tbl[r].vld, tbl[r].rf);
      chk("tbl_valid", cdb_valid, tbl[r].ev);
      chk("tbl_tag0", cdb_tag[0], tbl[r].et0);
      chk("tbl_val0", cdb_value[0], tbl[r].ev[0] ? XLEN'(tbl[r].et0) + 32'd2 : 32'd0);
      chk("tbl_tag1", cdb_tag[1], tbl[r].et1);
      chk("tbl_val1", cdb_value[1], tbl[r].ev[1] ? XLEN'(tbl[r].et1) + 32'd2 : 32'd0);
      chk("tbl_ready", fu_ready, 4'hF);
    end

    // FU1 streams back-to-back, issue gated by fu_ready.
    drops = 0; bcasts = 0;
    for (int c = 0; c < 30; c++) begin
      fu_tag = '0; fu_result = '0;
      fu_tag[1] = ROB_IDX_W'(c); fu_result[1] = 32'h1000 + c;
      if (!fu_ready[1]) drops++;
      step({2'b00, fu_ready[1], 1'b0}, 1'b0);
      if (cdb_valid == 2'b01) bcasts++;
    end
    chk("stream_ready_drops", drops, 0);
    chk("stream_bcasts", bcasts, 29);
    chk("stream_no_overflow", overflow_err, 1'b0);
    fu_tag = '0; fu_result = '0;
    step('0, 1'b0);

    // All FUs contend while FU0 is forced every cycle past fu_ready.
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < NF; i++) begin
        fu_tag[i] = ROB_IDX_W'(c + 8 * i); fu_result[i] = 32'hA000 + 32'(16 * i + c);
      end
      step(4'b0001 | (4'b1110 & fu_ready), 1'b0);
    end
    chk("ovf_set", overflow_err, 1'b1);
    for (int c = 0; c < 12; c++) step('0, 1'b0);
    chk("ovf_sticky", overflow_err, 1'b1);
    chk("drained_ready", fu_ready, 4'hF);

    // Asynchronous reset in the middle of a burst.
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < NF; i++) begin
        fu_tag[i] = ROB_IDX_W'($urandom); fu_result[i] = $urandom;
      end
      step(4'hF, 1'b0);
    end
    chk("burst_active", cdb_valid, 2'b11);
    #2 reset = 1'b0;
    #1;
    chk("arst_cdb_valid", cdb_valid, '0);
    chk("arst_cdb_tag", cdb_tag, '0);
    chk("arst_fu_ready", fu_ready, 4'hF);
    chk("arst_overflow", overflow_err, 1'b0);
    model_reset();
    @(negedge clock);
    reset = 1'b1;

    // Randomized traffic with occasional refresh.
    for (int c = 0; c < 400; c++) begin
      logic [NF-1:0] v;
      for (int i = 0; i < NF; i++) begin
        fu_tag[i] = ROB_IDX_W'($urandom); fu_result[i] = $urandom;
      end
      v = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) v = v & fu_ready;
      step(v, $urandom_range(0, 19) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
